// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants, opcodes and FSM state for the cpu execute stage
package cpu_pkg;

  localparam int CPU_DATA_W  = 8;
  localparam int CPU_REG_CNT = 4;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_MUL = 4'hA;
  localparam logic [3:0] OP_CMP = 4'hB;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } ex_state_t;

  // Low bit of register idx within the packed regs bus.
  function automatic int reg_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/cpu_mul_seq.sv
// rtl/cpu_mul_seq.sv - sequential shift-add multiplier, one multiplier bit per cycle
module cpu_mul_seq #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                done,
  output logic [2*DATA_W-1:0] prod
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic                running;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplier;
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] acc_next;

  // prod is the accumulator value being written on this edge, so the final
  // product is available to the caller on the same edge that done is high.
  always_comb begin
    acc_next = acc;
    if (mplier[cnt]) begin
      acc_next = acc + (mcand << cnt);
    end
  end

  assign done = running && (cnt == CNT_W'(DATA_W - 1));
  assign prod = acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      mcand   <= {{DATA_W{1'b0}}, a};
      mplier  <= b;
      acc     <= '0;
    end else if (running) begin
      acc <= acc_next;
      cnt <= cnt + 1'b1;
      if (done) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cpu_ex.sv
// rtl/cpu_ex.sv - execute/writeback stage: ALU, register file and multi-cycle MUL control
module cpu_ex
  import cpu_pkg::*;
#(
  parameter int DATA_W  = CPU_DATA_W,
  parameter int REG_CNT = CPU_REG_CNT,
  localparam int IDX_W  = $clog2(REG_CNT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                opcode,
  input  logic [DATA_W-1:0]         in1_val,
  input  logic [DATA_W-1:0]         in2_val,
  input  logic [IDX_W-1:0]          dst_idx,
  output logic [REG_CNT*DATA_W-1:0] regs,
  output logic                      flag_z,
  output logic                      flag_c,
  output logic                      wb_valid,
  output logic [IDX_W-1:0]          wb_idx,
  output logic [DATA_W-1:0]         wb_data,
  output logic                      illegal,
  output logic                      busy
);

  ex_state_t           state, state_next;
  logic [DATA_W-1:0]   rf [REG_CNT];
  logic [IDX_W-1:0]    mul_dst;
  logic                accept;

  logic [DATA_W:0]     res;
  logic                res_c;
  logic                do_write;
  logic                do_flags;
  logic                is_illegal;
  logic                mul_start;
  logic                mul_done;
  logic [2*DATA_W-1:0] mul_prod;

  assign busy     = (state == ST_MUL);
  assign in_ready = !busy;
  assign accept   = in_valid && in_ready;

  for (genvar i = 0; i < REG_CNT; i++) begin : g_regs
    assign regs[reg_lsb(i, DATA_W) +: DATA_W] = rf[i];
  end

  always_comb begin
    res        = '0;
    res_c      = 1'b0;
    do_write   = 1'b0;
    do_flags   = 1'b0;
    is_illegal = 1'b0;
    mul_start  = 1'b0;
    case (opcode)
      OP_NOP: ;
      OP_MOV: begin res = {1'b0, in2_val};            do_write = 1'b1; do_flags = 1'b1; end
      OP_ADD: begin
        res   = {1'b0, in1_val} + {1'b0, in2_val};
        res_c = res[DATA_W];
        do_write = 1'b1; do_flags = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        // The extra top bit of a zero-extended subtract is the borrow.
        res   = {1'b0, in1_val} - {1'b0, in2_val};
        res_c = res[DATA_W];
        do_write = (opcode == OP_SUB); do_flags = 1'b1;
      end
      OP_AND: begin res = {1'b0, in1_val & in2_val};  do_write = 1'b1; do_flags = 1'b1; end
      OP_OR:  begin res = {1'b0, in1_val | in2_val};  do_write = 1'b1; do_flags = 1'b1; end
      OP_XOR: begin res = {1'b0, in1_val ^ in2_val};  do_write = 1'b1; do_flags = 1'b1; end
      OP_NOT: begin res = {1'b0, ~in2_val};           do_write = 1'b1; do_flags = 1'b1; end
      OP_SHL: begin res = {1'b0, in1_val << in2_val[2:0]}; do_write = 1'b1; do_flags = 1'b1; end
      OP_SHR: begin res = {1'b0, in1_val >> in2_val[2:0]}; do_write = 1'b1; do_flags = 1'b1; end
      OP_MUL: mul_start = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept && mul_start) state_next = ST_MUL;
      ST_MUL:  if (mul_done)            state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  cpu_mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && mul_start),
    .a     (in1_val),
    .b     (in2_val),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      for (int i = 0; i < REG_CNT; i++) rf[i] <= '0;
      mul_dst  <= '0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      wb_valid <= 1'b0;
      wb_idx   <= '0;
      wb_data  <= '0;
      illegal  <= 1'b0;
    end else begin
      state    <= state_next;
      wb_valid <= 1'b0;
      illegal  <= 1'b0;
      if (accept) begin
        illegal <= is_illegal;
        if (mul_start) mul_dst <= dst_idx;
        if (do_flags) begin
          flag_z <= (res[DATA_W-1:0] == '0);
          flag_c <= res_c;
        end
        if (do_write) begin
          rf[dst_idx] <= res[DATA_W-1:0];
          wb_valid    <= 1'b1;
          wb_idx      <= dst_idx;
          wb_data     <= res[DATA_W-1:0];
        end
      end else if (mul_done) begin
        rf[mul_dst] <= mul_prod[DATA_W-1:0];
        flag_z      <= (mul_prod[DATA_W-1:0] == '0);
        flag_c      <= (mul_prod[2*DATA_W-1:DATA_W] != '0);
        wb_valid    <= 1'b1;
        wb_idx      <= mul_dst;
        wb_data     <= mul_prod[DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_cpu_ex.sv
// tb/tb_cpu_ex.sv - self-checking bench for cpu_ex with a writeback scoreboard
module tb_cpu_ex;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [7:0]  in1_val;
  logic [7:0]  in2_val;
  logic [1:0]  dst_idx;
  logic [31:0] regs;
  logic        flag_z, flag_c;
  logic        wb_valid;
  logic [1:0]  wb_idx;
  logic [7:0]  wb_data;
  logic        illegal;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] idx;
    logic [7:0] data;
  } wb_t;
  wb_t sb [$];

  cpu_ex dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opcode   (opcode),
    .in1_val  (in1_val),
    .in2_val  (in2_val),
    .dst_idx  (dst_idx),
    .regs     (regs),
    .flag_z   (flag_z),
    .flag_c   (flag_c),
    .wb_valid (wb_valid),
    .wb_idx   (wb_idx),
    .wb_data  (wb_data),
    .illegal  (illegal),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for exactly one edge, then drop in_valid.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] d);
    opcode   = op;
    in1_val  = a;
    in2_val  = b;
    dst_idx  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic push(input logic [1:0] idx, input logic [7:0] data);
    wb_t e;
    e.idx  = idx;
    e.data = data;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (wb_valid) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", 32'd1, 32'd0);
      end else begin
        wb_t e;
        e = sb.pop_front();
        check("wb_idx", {30'd0, wb_idx}, {30'd0, e.idx});
        check("wb_data", {24'd0, wb_data}, {24'd0, e.data});
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    opcode   = 4'h0;
    in1_val  = 8'h00;
    in2_val  = 8'h00;
    dst_idx  = 2'd0;
    tick(); tick(); tick();

    check("rst_regs", regs, 32'h0);
    check("rst_flags", {30'd0, flag_z, flag_c}, 32'd0);
    check("rst_wb", {21'd0, wb_valid, wb_idx, wb_data}, 32'd0);
    check("rst_ctl", {29'd0, illegal, busy, in_ready}, 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_regs", regs, 32'h0);
      check("idle_ready", {31'd0, in_ready}, 32'd1);
    end

    // Back-to-back MOV then ADD into r1.
    push(2'd1, 8'h05);
    issue(4'h1, 8'h00, 8'h05, 2'd1);
    check("mov_r1", regs, 32'h0000_0500);
    check("mov_zc", {30'd0, flag_z, flag_c}, 32'd0);
    check("mov_wbv", {31'd0, wb_valid}, 32'd1);
    push(2'd1, 8'h00);
    issue(4'h2, 8'h05, 8'hFB, 2'd1);
    check("add_r1", regs, 32'h0000_0000);
    check("add_zc", {30'd0, flag_z, flag_c}, 32'd3);
    check("add_wbv", {31'd0, wb_valid}, 32'd1);

    // SUB with borrow, then CMP equal (no write).
    push(2'd2, 8'h03);
    issue(4'h1, 8'h00, 8'h03, 2'd2);
    push(2'd2, 8'hFC);
    issue(4'h3, 8'h03, 8'h07, 2'd2);
    check("sub_r2", regs, 32'h00FC_0000);
    check("sub_zc", {30'd0, flag_z, flag_c}, 32'd1);
    issue(4'hB, 8'h07, 8'h07, 2'd2);
    check("cmp_r2", regs, 32'h00FC_0000);
    check("cmp_zc", {30'd0, flag_z, flag_c}, 32'd2);
    check("cmp_nowb", {31'd0, wb_valid}, 32'd0);

    // MUL with in_valid held: next MOV waits until the cycle after T8.
    push(2'd3, 8'h13);
    issue(4'h1, 8'h00, 8'h13, 2'd3);
    opcode = 4'hA; in1_val = 8'h13; in2_val = 8'h11; dst_idx = 2'd3; in_valid = 1'b1;
    push(2'd3, 8'h43);
    tick();
    opcode = 4'h1; in1_val = 8'h00; in2_val = 8'hAA; dst_idx = 2'd0;
    for (int k = 0; k < 8; k++) begin
      check("mul_busy", {30'd0, busy, in_ready}, 32'd2);
      tick();
    end
    check("mul_done_ctl", {30'd0, busy, in_ready}, 32'd1);
    check("mul_r3", regs, 32'h43FC_0000);
    check("mul_zc", {30'd0, flag_z, flag_c}, 32'd1);
    push(2'd0, 8'hAA);
    tick();
    in_valid = 1'b0;
    check("post_mul_mov", regs, 32'h43FC_00AA);

    // Preset Z=1 C=1, then reserved opcode D and NOP.
    push(2'd1, 8'h00);
    issue(4'h2, 8'h80, 8'h80, 2'd1);
    check("preset_zc", {30'd0, flag_z, flag_c}, 32'd3);
    issue(4'hD, 8'h12, 8'h34, 2'd2);
    check("rsv_illegal", {31'd0, illegal}, 32'd1);
    check("rsv_nowb", {31'd0, wb_valid}, 32'd0);
    check("rsv_zc", {30'd0, flag_z, flag_c}, 32'd3);
    check("rsv_regs", regs, 32'h43FC_00AA);
    issue(4'h0, 8'h12, 8'h34, 2'd2);
    check("nop_illegal", {31'd0, illegal}, 32'd0);
    check("nop_nowb", {31'd0, wb_valid}, 32'd0);
    check("nop_zc", {30'd0, flag_z, flag_c}, 32'd3);
    check("nop_regs", regs, 32'h43FC_00AA);

    // Reset four cycles into a MUL to r0.
    issue(4'hA, 8'h03, 8'h05, 2'd0);
    tick(); tick(); tick();
    check("mul2_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", {30'd0, busy, in_ready}, 32'd1);
    check("mrst_regs", regs, 32'h0);
    check("mrst_wb", {31'd0, wb_valid}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("mrst_quiet", {31'd0, wb_valid}, 32'd0);
    end
    push(2'd0, 8'h07);
    issue(4'h2, 8'h00, 8'h07, 2'd0);
    check("after_rst_r0", regs, 32'h0000_0007);
    check("after_rst_zc", {30'd0, flag_z, flag_c}, 32'd0);
    tick(); tick();

    check("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_ex.md
Name: cpu_ex

Overview:
Execute/writeback stage of the 8-bit, 4-register CPU, directly downstream of decode.
- Consumes decoded opcode, operand values and destination index.
- Computes the ALU result and owns the register file.
- Drives the register file back to decode as a packed bus.
- Single-cycle ops complete on acceptance. MUL is a multi-cycle shift-add that back-pressures decode through a valid/ready handshake.

Parameters:
DATA_W, 8, operand/register width; MUL takes DATA_W cycles
REG_CNT, 4, number of architectural registers; IDX_W = clog2(REG_CNT)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  decode presents an instruction
in_ready  output  1  stage can accept; equals !busy (combinational from state)
opcode  input  4  operation code
in1_val  input  DATA_W  first operand (value of destination register)
in2_val  input  DATA_W  second operand
dst_idx  input  IDX_W  destination register index
regs  output  REG_CNT*DATA_W  register file, register i at [DATA_W*i+DATA_W-1 : DATA_W*i]
flag_z  output  1  zero flag
flag_c  output  1  carry/borrow flag
wb_valid  output  1  one-cycle pulse: a register write happened on the previous edge
wb_idx  output  IDX_W  index of that write
wb_data  output  DATA_W  data of that write
illegal  output  1  one-cycle pulse: a reserved opcode was accepted
busy  output  1  MUL in progress

Behaviour:
- Reset (asynchronous, active-low) values:
  - all regs 0; flag_z 0; flag_c 0.
  - wb_valid 0; wb_idx 0; wb_data 0.
  - illegal 0; busy 0; in_ready 1.
- Accept occurs on a rising edge with in_valid && in_ready. Inputs are ignored otherwise.
- Opcode map:
  - 0 NOP.
  - 1 MOV: d = in2.
  - 2 ADD: d = in1 + in2; C = carry out.
  - 3 SUB: d = in1 - in2; C = borrow (in1 < in2).
  - 4 AND.
  - 5 OR.
  - 6 XOR.
  - 7 NOT: d = ~in2.
  - 8 SHL: d = in1 << in2[2:0].
  - 9 SHR: d = in1 >> in2[2:0], logical.
  - A MUL: d = low DATA_W bits of in1*in2; C = high half nonzero.
  - B CMP: flags as SUB, no write.
  - C-F reserved.
- Flag rules:
  - Z = (result low DATA_W bits == 0) for ops 1-B.
  - C = 0 for MOV, logic ops and shifts.
  - NOP and reserved opcodes leave flags unchanged.
- Single-cycle ops (1-9, B):
  - regs[dst_idx] and the flags update on the accepting edge T0.
  - wb_valid/wb_idx/wb_data are registered and high for the cycle after T0.
  - in_ready stays 1, so back-to-back accepts are allowed every cycle.
- NOP: no write, no wb_valid pulse.
- Reserved opcodes: no write, flags unchanged, illegal = 1 for the cycle after T0.
- MUL FSM, states IDLE and MUL:
  - IDLE -> MUL on accept of opcode A. Latch multiplicand, multiplier and dst_idx; clear the 2*DATA_W accumulator and the counter.
  - In MUL: busy = 1 and in_ready = 0. Each cycle, if the current multiplier bit is 1, add the shifted multiplicand to the accumulator; then increment the counter.
  - On the edge where the counter reaches DATA_W-1 (edge T0+DATA_W, i.e. T8 at default): write regs[latched dst], update flags, return to IDLE.
  - wb_valid pulses the cycle after T8. in_ready returns to 1 in that same cycle.
- Behaviour while busy:
  - Inputs are ignored even if in_valid is high.
  - Decode must hold its instruction until accepted.
- No internal forwarding:
  - regs shows a write from the cycle after its edge.
  - Decode sees updated values combinationally from then on.
- Same-register dependencies are correct because a write on edge T is visible before edge T+1.
- Reset mid-MUL: return to IDLE immediately, discard the result, no write, no wb_valid.

Decomposition:
- cpu_pkg holds:
  - DATA_W/REG_CNT defaults;
  - opcode localparams OP_NOP..OP_CMP;
  - the FSM state enum;
  - a helper function for the packed regs slice.
- One sub-module: cpu_mul_seq, the sequential shift-add multiplier.
  - Interface: start, a, b, done, prod[2*DATA_W-1:0].
  - Instantiated once in cpu_ex.

Test Plan:
- Reset held, then released with in_valid=0 -> all outputs 0 except in_ready=1; regs stays 0 for 5 cycles.
- Back-to-back MOV r1<-0x05, ADD r1(0x05)+0xFB -> cycle 1 r1=0x05, Z=0 C=0; cycle 2 r1=0x00, Z=1 C=1; two consecutive wb_valid pulses with wb_idx=1.
- SUB r2(0x03)-0x07, then CMP 0x07 vs 0x07 -> r2=0xFC C=1 Z=0; after CMP r2 unchanged, Z=1 C=0, no wb_valid pulse for the CMP.
- MUL r3(0x13)*0x11 with in_valid held high throughout -> busy/in_ready low for exactly 8 cycles; r3=0x43 written at T8; C=1 (0x0143); the next instruction is accepted only in the cycle after T8.
- Opcodes 0xD and 0x0 with flags preset Z=1 C=1 -> illegal pulses once for 0xD only; flags and regs unchanged; no wb_valid.
- rst_n asserted 4 cycles into a MUL to r0 -> busy=0 immediately; r0=0; no wb_valid; first instruction after release executes normally.
